// File: rtl/mdu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared encodings, states and constants for the multiply/divide unit
// Revision : 1.0
// ============================================================================
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam int          MDU_ITER  = 32;
    localparam logic [3:0]  ALUOP_MDU = 4'b1000;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_t;

    // Two's-complement magnitude; INT_MIN maps to 2^31, which fits unsigned.
    function automatic logic [31:0] mdu_mag(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_addsub33.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mdu_addsub33
// Purpose  : 33-bit combinational adder/subtractor (sub = invert y, carry in 1)
// Revision : 1.0
// ============================================================================
module mdu_addsub33 (
    input  logic [32:0] x,
    input  logic [32:0] y,
    input  logic        sub,
    output logic [32:0] sum
);

    logic [32:0] w_y;

    assign w_y = y ^ {33{sub}};
    assign sum = x + w_y + {32'd0, sub};

endmodule
`default_nettype wire

// File: rtl/mdu32.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mdu32
// Purpose  : Iterative 32-cycle multiply/divide unit with HI/LO result registers
// Revision : 1.0
// ============================================================================
module mdu32
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam logic [4:0] c_last = 5'(MDU_ITER - 1);

    mdu_state_t  r_state;
    mdu_state_t  w_next;

    logic [4:0]  r_cnt;
    logic [1:0]  r_op;
    logic        r_sa;
    logic        r_sb;
    logic        r_bzero;
    logic [31:0] r_araw;
    logic [31:0] r_y;
    logic [63:0] r_acc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_dz;

    logic        w_isdiv;
    logic        w_sa;
    logic        w_sb;
    logic [32:0] w_add_x;
    logic [32:0] w_add_y;
    logic [32:0] w_sum;
    logic        w_neg;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_isdiv = r_op[1];
    assign w_sa    = ~op[0] & a[31];
    assign w_sb    = ~op[0] & b[31];
    assign w_neg   = r_sa ^ r_sb;

    // Multiply adds the multiplicand into the upper half; divide trial-subtracts
    // the divisor from the remainder shifted left with the next dividend bit.
    always_comb begin
        if (w_isdiv) begin
            w_add_x = r_acc[63:31];
            w_add_y = {1'b0, r_y};
        end else begin
            w_add_x = {1'b0, r_acc[63:32]};
            w_add_y = r_acc[0] ? {1'b0, r_y} : 33'd0;
        end
    end

    mdu_addsub33 u_addsub (
        .x   (w_add_x),
        .y   (w_add_y),
        .sub (w_isdiv),
        .sum (w_sum)
    );

    assign w_prod = w_neg ? (64'd0 - r_acc) : r_acc;
    assign w_quot = w_neg ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem  = r_sa  ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_RUN;
                S_RUN:   if (r_cnt == c_last) w_next = S_FIX;
                S_FIX:   w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 5'd0;
            r_op    <= 2'd0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_bzero <= 1'b0;
            r_araw  <= 32'd0;
            r_y     <= 32'd0;
            r_acc   <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_dz    <= 1'b0;
        end else if (flush) begin
            r_cnt   <= 5'd0;
            r_op    <= 2'd0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_bzero <= 1'b0;
            r_araw  <= 32'd0;
            r_y     <= 32'd0;
            r_acc   <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt   <= 5'd0;
                        r_op    <= op;
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_bzero <= (b == 32'd0);
                        r_araw  <= a;
                        if (op[1]) begin
                            r_y   <= mdu_mag(b, w_sb);
                            r_acc <= {32'd0, mdu_mag(a, w_sa)};
                        end else begin
                            r_y   <= mdu_mag(a, w_sa);
                            r_acc <= {32'd0, mdu_mag(b, w_sb)};
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (!w_isdiv) begin
                        r_acc <= {w_sum, r_acc[31:1]};
                    end else if (!w_sum[32]) begin
                        r_acc <= {w_sum[31:0], r_acc[30:0], 1'b1};
                    end else begin
                        r_acc <= {r_acc[62:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (!w_isdiv) begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                        r_dz <= 1'b0;
                    end else if (r_bzero) begin
                        r_hi <= r_araw;
                        r_lo <= DIV0_QUOT;
                        r_dz <= 1'b1;
                    end else begin
                        // INT_MIN / -1 lands here naturally: |q| = 2^31, signs equal.
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                        r_dz <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN) || (r_state == S_FIX);
    assign done = (r_state == S_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign dz   = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_mdu32.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mdu32
// Purpose  : Directed vector bench for mdu32 with multi-cycle corner sequences
// Revision : 1.0
// ============================================================================
module tb_mdu32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;

    int n_cmp;
    int n_bad;

    mdu32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; lat = edges after accept.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic bz);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bz  = busy;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int   lat;
        logic bz;
        int   ndone;

        n_cmp = 0; n_bad = 0;
        start = 1'b0; flush = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_dz", {31'd0, dz}, 32'd0);
        rst_n = 1'b1;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{2'b00, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[5]  = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[7]  = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[10] = '{2'b01, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800, 1'b0};
        vecs[11] = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
        vecs[12] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[13] = '{2'b00, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bz);
            check($sformatf("v%0d_busy", i), {31'd0, bz}, 32'd1);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
            check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            check($sformatf("v%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].dz});
        end

        // Start re-asserted mid-run must not disturb DIVU 100/7.
        @(negedge clk);
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 5 || c == 20) begin
                op = 2'b01; a = 32'd1; b = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) ndone++;
        end
        check("restart_ndone", 32'(ndone), 32'd1);
        check("restart_hi", hi, 32'd2);
        check("restart_lo", lo, 32'd14);

        // Flush at iteration 10: back to IDLE, no done, HI/LO held.
        @(negedge clk);
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush_ndone", 32'(ndone), 32'd0);
        check("flush_hi", hi, 32'd2);
        check("flush_lo", lo, 32'd14);
        check("flush_dz", {31'd0, dz}, 32'd0);

        // Async reset at iteration 16 clears everything immediately.
        @(negedge clk);
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_dz", {31'd0, dz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b01, 32'd3, 32'd4, lat, bz);
        check("post_rst_latency", 32'(lat), 32'd33);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
